// File: rtl/keypad_event_decoder_pkg.sv
// Shared types and constants for the keypad event decoder.
// Holds the row strobe constants, frame-result and FSM enums, and a one-hot encoder.
package keypad_pkg;

  localparam int KEY_W = 4;

  localparam logic [3:0] ROW0 = 4'b0001;
  localparam logic [3:0] ROW1 = 4'b0010;
  localparam logic [3:0] ROW2 = 4'b0100;
  localparam logic [3:0] ROW3 = 4'b1000;

  typedef enum logic [1:0] {NONE, SINGLE, MULTI, INVALID} frame_res_t;

  typedef enum logic [1:0] {IDLE, CAND, EMIT, HELD} key_state_t;

  function automatic logic [1:0] onehot_enc(input logic [3:0] v);
    case (v)
      ROW1:    return 2'd1;
      ROW2:    return 2'd2;
      ROW3:    return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/keypad_event_decoder_if.sv
// Key event handshake toward the request queue, plus the multi-key indication.
interface keypad_event_decoder_if;
  import keypad_pkg::*;

  logic             key_valid;
  logic [KEY_W-1:0] key_code;
  logic             key_ready;
  logic             multi_key;

  modport master (output key_valid, output key_code, output multi_key, input key_ready);
  modport slave  (input key_valid, input key_code, input multi_key, output key_ready);

endinterface

// File: rtl/keypad_event_decoder_accum.sv
// Classifies each scan sample and folds one ROW0..ROW3 sweep into a registered frame result.
module scan_frame_accumulator
  import keypad_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       row,
  input  logic [3:0]       col,
  output logic             frame_done,
  output frame_res_t       frame_res,
  output logic [KEY_W-1:0] frame_code,
  output logic             multi_pulse
);

  logic             open_q;
  logic [1:0]       hits_q;
  logic             multi_q;
  logic             invalid_q;
  logic [KEY_W-1:0] code_q;

  logic             row_ok;
  logic             starting;
  logic             closing;
  logic             restart;
  logic             sample_hit;
  logic             sample_multi;
  logic [1:0]       cur_hits;
  logic             cur_multi;
  logic             cur_invalid;
  logic [KEY_W-1:0] cur_code;
  frame_res_t       close_res;

  // cur_* is the frame state including the current sample; a ROW0 sample starts from scratch.
  // hits saturates at 2, which already means MULTI.
  always_comb begin
    row_ok       = $onehot(row);
    starting     = (row == ROW0);
    closing      = (row == ROW3) && open_q;
    restart      = starting && open_q;
    sample_hit   = row_ok && $onehot(col);
    sample_multi = row_ok && (col != 4'b0000) && !$onehot(col);
    cur_hits     = starting ? 2'd0 : hits_q;
    cur_code     = starting ? '0 : code_q;
    cur_multi    = (starting ? 1'b0 : multi_q) | sample_multi;
    cur_invalid  = (starting ? 1'b0 : invalid_q) | !row_ok;
    if (sample_hit) begin
      if (cur_hits == 2'd0) cur_code = {onehot_enc(row), onehot_enc(col)};
      if (cur_hits != 2'd2) cur_hits = cur_hits + 2'd1;
    end
    if (cur_invalid)                        close_res = INVALID;
    else if (cur_multi || cur_hits == 2'd2) close_res = MULTI;
    else if (cur_hits == 2'd1)              close_res = SINGLE;
    else                                    close_res = NONE;
  end

  // A second ROW0 before ROW3 reports the abandoned frame as INVALID and opens a new one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done  <= 1'b0;
      frame_res   <= NONE;
      frame_code  <= '0;
      multi_pulse <= 1'b0;
      open_q      <= 1'b0;
      hits_q      <= 2'd0;
      multi_q     <= 1'b0;
      invalid_q   <= 1'b0;
      code_q      <= '0;
    end else begin
      frame_done  <= closing | restart;
      frame_res   <= restart ? INVALID : close_res;
      frame_code  <= closing ? cur_code : '0;
      multi_pulse <= closing && (close_res == MULTI);
      open_q      <= starting | (open_q & ~closing);
      if ((starting || open_q) && !closing) begin
        hits_q    <= cur_hits;
        multi_q   <= cur_multi;
        invalid_q <= cur_invalid;
        code_q    <= cur_code;
      end else begin
        hits_q    <= 2'd0;
        multi_q   <= 1'b0;
        invalid_q <= 1'b0;
        code_q    <= '0;
      end
    end
  end

endmodule

// File: rtl/keypad_event_decoder.sv
// Keypad event decoder top: debounces frame results and emits one event per physical press.
module keypad_event_decoder
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int RELEASE_FRAMES  = 4,
  parameter int CNT_W           = 8
)
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [3:0]             row,
  input  logic [3:0]             col,
  keypad_event_decoder_if.master bus
);

  localparam logic [CNT_W-1:0] DEB_LIM = CNT_W'(DEBOUNCE_FRAMES);
  localparam logic [CNT_W-1:0] REL_LIM = CNT_W'(RELEASE_FRAMES);

  logic             frame_done;
  frame_res_t       frame_res;
  logic [KEY_W-1:0] frame_code;
  logic             multi_pulse;

  key_state_t       state, state_n;
  logic [KEY_W-1:0] cand, cand_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  scan_frame_accumulator u_accum (
    .clk         (clk),
    .rst_n       (rst_n),
    .row         (row),
    .col         (col),
    .frame_done  (frame_done),
    .frame_res   (frame_res),
    .frame_code  (frame_code),
    .multi_pulse (multi_pulse)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cand  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cand  <= cand_n;
      cnt   <= cnt_n;
    end
  end

  // EMIT ignores frames entirely so a release during backpressure cannot cancel the event.
  always_comb begin
    state_n = state;
    cand_n  = cand;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (frame_done && frame_res == SINGLE) begin
          cand_n  = frame_code;
          cnt_n   = CNT_W'(1);
          state_n = (DEBOUNCE_FRAMES == 1) ? EMIT : CAND;
        end
      end
      CAND: begin
        if (frame_done) begin
          if (frame_res == SINGLE) begin
            if (frame_code == cand) begin
              cnt_n = sat_inc(cnt);
              if (cnt_n >= DEB_LIM) state_n = EMIT;
            end else begin
              cand_n  = frame_code;
              cnt_n   = CNT_W'(1);
              state_n = (DEBOUNCE_FRAMES == 1) ? EMIT : CAND;
            end
          end else begin
            cnt_n   = '0;
            state_n = IDLE;
          end
        end
      end
      EMIT: begin
        if (bus.key_ready) begin
          cnt_n   = '0;
          state_n = HELD;
        end
      end
      HELD: begin
        if (frame_done) begin
          if (frame_res == NONE) begin
            cnt_n = sat_inc(cnt);
            if (cnt_n >= REL_LIM) begin
              cnt_n   = '0;
              state_n = IDLE;
            end
          end else begin
            cnt_n = '0;
          end
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  assign bus.key_valid = (state == EMIT);
  assign bus.key_code  = cand;
  assign bus.multi_key = multi_pulse;

endmodule
